soc_system_pio_ctrl: RTL and testbench

Parametrised Avalon-MM general-purpose I/O block. It generalises the single-bit write-only control PIO used for camera power-down and reset lines to WIDTH bits. It adds atomic set/clear writes, a hardware-timed pulse mode (self-clearing output bits), synchronised inputs with edge capture, and a maskable interrupt. It sits on the HPS lightweight bridge, one instance per peripheral control/status group.

---
 rtl/soc_system_pio_ctrl.sv | 164 ++++++++++++++++
 tb/tb_soc_system_pio_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_ctrl.sv
// soc_system_pio_ctrl: Avalon-MM general-purpose I/O block with atomic set/clear,
// self-clearing pulse outputs, synchronised inputs with edge capture and a maskable irq.
//
// Ports:
//   clk         system clock (rising edge)
//   reset       synchronous active-high reset
//   address     Avalon word address (0 DATA, 1 OUT, 2 IRQMASK, 3 EDGE, 4 OUTSET,
//               5 OUTCLR, 6 PULSE, 7 reserved)
//   chipselect  slave select; write when chipselect && !write_n
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, 1 cycle latency, follows address every cycle
//   in_port     asynchronous external inputs
//   out_port    output register
//   irq         registered level interrupt, |(edge_cap & irqmask)
module soc_system_pio_ctrl #(
   parameter int unsigned WIDTH       = 8,
   parameter logic [31:0] RESET_VALUE = 32'h0,
   parameter int unsigned EDGE_TYPE   = 0,
   parameter int unsigned PULSE_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] AddrData    = 3'd0;
   localparam logic [2:0] AddrOut     = 3'd1;
   localparam logic [2:0] AddrIrqMask = 3'd2;
   localparam logic [2:0] AddrEdge    = 3'd3;
   localparam logic [2:0] AddrOutSet  = 3'd4;
   localparam logic [2:0] AddrOutClr  = 3'd5;
   localparam logic [2:0] AddrPulse   = 3'd6;

   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   irqmask_q, irqmask_d;
   logic [WIDTH-1:0]   edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0]   sync1_q, in_sync_q, in_prev_q;
   logic [WIDTH-1:0]   pulse_mask_q, pulse_mask_d;
   logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic               busy_q, busy_d;
   logic [31:0]        readdata_q, readdata_d;
   logic               irq_q, irq_d;

   logic               wr;
   logic [WIDTH-1:0]   wd;
   logic [WIDTH-1:0]   edge_det;
   logic [31:0]        cnt_wide;
   logic [PULSE_W-1:0] pulse_n;
   logic [31:0]        cnt_ext;
   logic               unused_bits;

   assign wr       = chipselect & ~write_n;
   assign wd       = writedata[WIDTH-1:0];
   assign cnt_wide = {16'h0, writedata[31:16]};
   assign pulse_n  = cnt_wide[PULSE_W-1:0];
   assign cnt_ext  = 32'(pulse_cnt_q);
   assign unused_bits = ^{writedata, cnt_wide, cnt_ext};

   always_comb begin
      if (EDGE_TYPE == 0) begin
         edge_det = in_sync_q & ~in_prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_det = ~in_sync_q & in_prev_q;
      end else begin
         edge_det = in_sync_q ^ in_prev_q;
      end
   end

   // Pulse expiry is evaluated first so that a bus write in the same cycle overrides it.
   always_comb begin
      out_d        = out_q;
      pulse_mask_d = pulse_mask_q;
      pulse_cnt_d  = pulse_cnt_q;
      busy_d       = busy_q;
      irqmask_d    = irqmask_q;
      edge_cap_d   = edge_cap_q | edge_det;

      if (busy_q) begin
         if (pulse_cnt_q == PULSE_W'(1)) begin
            out_d        = out_q & ~pulse_mask_q;
            pulse_mask_d = '0;
            pulse_cnt_d  = '0;
            busy_d       = 1'b0;
         end else begin
            pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
         end
      end

      if (wr) begin
         case (address)
            AddrData:    out_d     = wd;
            AddrIrqMask: irqmask_d = wd;
            // Set wins over a simultaneous clear.
            AddrEdge:    edge_cap_d = (edge_cap_q & ~wd) | edge_det;
            AddrOutSet:  out_d     = out_d | wd;
            AddrOutClr:  out_d     = out_d & ~wd;
            AddrPulse: begin
               out_d = out_d | wd;
               // A zero count behaves as OUTSET; otherwise the new pulse merges and restarts.
               if (pulse_n != '0) begin
                  pulse_mask_d = pulse_mask_q | wd;
                  pulse_cnt_d  = pulse_n;
                  busy_d       = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         AddrData:    readdata_d = 32'(in_sync_q);
         AddrOut:     readdata_d = 32'(out_q);
         AddrIrqMask: readdata_d = 32'(irqmask_q);
         AddrEdge:    readdata_d = 32'(edge_cap_q);
         AddrPulse:   readdata_d = {busy_q, 15'b0, cnt_ext[15:0]};
         default:     readdata_d = '0;
      endcase
      irq_d = |(edge_cap_q & irqmask_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= RESET_VALUE[WIDTH-1:0];
         irqmask_q    <= '0;
         edge_cap_q   <= '0;
         sync1_q      <= '0;
         in_sync_q    <= '0;
         in_prev_q    <= '0;
         pulse_mask_q <= '0;
         pulse_cnt_q  <= '0;
         busy_q       <= 1'b0;
         readdata_q   <= '0;
         irq_q        <= 1'b0;
      end else begin
         out_q        <= out_d;
         irqmask_q    <= irqmask_d;
         edge_cap_q   <= edge_cap_d;
         sync1_q      <= in_port;
         in_sync_q    <= sync1_q;
         in_prev_q    <= in_sync_q;
         pulse_mask_q <= pulse_mask_d;
         pulse_cnt_q  <= pulse_cnt_d;
         busy_q       <= busy_d;
         readdata_q   <= readdata_d;
         irq_q        <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = out_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_pio_ctrl.sv
// Self-checking bench for soc_system_pio_ctrl (WIDTH=8, RESET_VALUE=8'h01, rising edges).
module tb_soc_system_pio_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  exp_out;
   } vec_t;
   vec_t vecs[10];

   soc_system_pio_ctrl #(
      .WIDTH       (8),
      .RESET_VALUE (32'h01),
      .EDGE_TYPE   (0),
      .PULSE_W     (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .out_port   (out_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Expected value is queued when the address is presented and retired when readdata updates.
   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      sb_t e;
      address = a;
      sb_q.push_back('{name: name, exp: exp});
      tick();
      e = sb_q.pop_front();
      check(e.name, readdata, e.exp);
   endtask

   initial begin
      vecs[0] = '{addr: 3'd0, wdata: 32'h0000_00F0, exp_out: 8'hF0};
      vecs[1] = '{addr: 3'd4, wdata: 32'h0000_0003, exp_out: 8'hF3};
      vecs[2] = '{addr: 3'd5, wdata: 32'h0000_0010, exp_out: 8'hE3};
      vecs[3] = '{addr: 3'd1, wdata: 32'h0000_0000, exp_out: 8'hE3};
      vecs[4] = '{addr: 3'd7, wdata: 32'h0000_00FF, exp_out: 8'hE3};
      vecs[5] = '{addr: 3'd4, wdata: 32'hFFFF_FF08, exp_out: 8'hEB};
      vecs[6] = '{addr: 3'd5, wdata: 32'hFFFF_FF00, exp_out: 8'hEB};
      vecs[7] = '{addr: 3'd0, wdata: 32'h1234_565A, exp_out: 8'h5A};
      vecs[8] = '{addr: 3'd6, wdata: 32'h0000_0081, exp_out: 8'hDB};
      vecs[9] = '{addr: 3'd5, wdata: 32'h0000_00FF, exp_out: 8'h00};

      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      tick();
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_out_port", 32'(out_port), 32'h01);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_readdata", readdata, 32'h0);
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), (a == 1) ? 32'h01 : 32'h0, $sformatf("rst_read_a%0d", a));
      end

      // Register writes from the table
      for (int i = 0; i < 10; i++) begin
         bus_write(vecs[i].addr, vecs[i].wdata);
         check($sformatf("vec%0d_out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
         bus_read(3'd1, 32'(vecs[i].exp_out), $sformatf("vec%0d_out_read", i));
      end
      bus_read(3'd6, 32'h0, "zero_pulse_not_busy");
      bus_write(3'd2, 32'hABCD_12F0);
      bus_read(3'd2, 32'h0000_00F0, "irqmask_read");
      bus_read(3'd4, 32'h0, "outset_reads_0");
      bus_read(3'd5, 32'h0, "outclr_reads_0");

      // Single pulse, count 5 on bit 2
      bus_write(3'd6, {16'd5, 16'h0004});
      for (int k = 0; k < 5; k++) begin
         check($sformatf("pulse_high_%0d", k), 32'(out_port), 32'h04);
         bus_read(3'd6, 32'h8000_0000 | 32'(5 - k), $sformatf("pulse_cnt_%0d", k));
      end
      check("pulse_expired", 32'(out_port), 32'h00);
      bus_read(3'd6, 32'h0, "pulse_idle_read");

      // Overlapping pulses; OUTSET in the expiry cycle keeps bit 0
      bus_write(3'd6, {16'd10, 16'h0001});
      tick();
      tick();
      tick();
      bus_write(3'd6, {16'd3, 16'h0002});
      check("overlap_both_high", 32'(out_port), 32'h03);
      tick();
      tick();
      check("overlap_before_expiry", 32'(out_port), 32'h03);
      bus_write(3'd4, 32'h0000_0001);
      check("overlap_expiry_outset", 32'(out_port), 32'h01);
      bus_read(3'd6, 32'h0, "overlap_not_busy");
      check("overlap_bit0_stays", 32'(out_port), 32'h01);

      // Edge capture and irq
      bus_write(3'd2, 32'h0000_0002);
      in_port[1] = 1'b1;
      tick();
      tick();
      tick();
      check("edge_irq_lags", 32'(irq), 32'h0);
      bus_read(3'd3, 32'h02, "edge_captured");
      check("edge_irq_set", 32'(irq), 32'h1);
      in_port[1] = 1'b0;
      tick();
      tick();
      tick();
      tick();
      bus_read(3'd3, 32'h02, "falling_ignored");
      in_port[1] = 1'b1;
      tick();
      tick();
      bus_write(3'd3, 32'h0000_0002);
      check("w1c_vs_edge_irq", 32'(irq), 32'h1);
      bus_read(3'd3, 32'h02, "w1c_vs_edge_set_wins");
      check("w1c_vs_edge_irq_after", 32'(irq), 32'h1);
      bus_write(3'd3, 32'h0000_0002);
      bus_read(3'd3, 32'h00, "w1c_clears");
      check("w1c_irq_clear", 32'(irq), 32'h0);

      // Reset in the middle of a pulse with edge_cap set
      bus_write(3'd2, 32'h0000_0012);
      in_port[4] = 1'b1;
      tick();
      tick();
      tick();
      tick();
      bus_write(3'd6, {16'd20, 16'h0080});
      check("pre_rst_out", 32'(out_port), 32'h81);
      check("pre_rst_irq", 32'(irq), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_out_port", 32'(out_port), 32'h01);
      check("midrst_irq", 32'(irq), 32'h0);
      bus_read(3'd3, 32'h00, "midrst_edge_clear");
      bus_read(3'd6, 32'h00, "midrst_not_busy");
      bus_read(3'd2, 32'h00, "midrst_irqmask_clear");
      bus_read(3'd3, 32'h12, "held_high_recaptured");
      check("midrst_out_after", 32'(out_port), 32'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
